// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------------------------
// branch_predictor
//   Fetch-stage direct-mapped branch target buffer with a 2-bit saturating counter per entry.
//   The lookup is combinational on the registered table, so the prediction is available in the
//   same cycle as the fetch address. The table is trained by branches and jumps resolved in EX.
//   Two saturating statistics counters track resolved control transfers and mispredictions.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset; clears the table and statistics
//   IF_PC          fetch address (word aligned)
//   IF_hit         predicted taken (valid entry, tag match, counter MSB set)
//   IF_PC_Pred     predicted next PC: stored target on a hit, otherwise IF_PC + 4
//   EX_Branch      conditional branch resolved this cycle
//   EX_Jump        JAL/JALR resolved this cycle; wins over EX_Branch
//   EX_PC          PC of the resolving instruction
//   EX_Taken       actual outcome
//   EX_Target      actual target
//   EX_hit         prediction that was made for the resolving instruction
//   br_count       resolved branches and jumps, saturating
//   mispred_count  mispredictions, saturating
// ---------------------------------------------------------------------------------------------
module branch_predictor #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      IF_PC,
    output logic             IF_hit,
    output logic [31:0]      IF_PC_Pred,
    input  logic             EX_Branch,
    input  logic             EX_Jump,
    input  logic [31:0]      EX_PC,
    input  logic             EX_Taken,
    input  logic [31:0]      EX_Target,
    input  logic             EX_hit,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned TAG_W   = 30 - IDX_W;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Table storage
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_mispred_count;

    // Lookup side
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;

    // Update side
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_match;
    logic             w_upd;
    logic             w_mispred;
    logic             w_wr_en;
    logic [31:0]      w_wr_target;
    logic [1:0]       w_wr_ctr;

    // Address bits below the word offset carry no information.
    logic             w_unused_pc_lsbs;
    assign w_unused_pc_lsbs = ^{IF_PC[1:0], EX_PC[1:0]};

    // -----------------------------------------------------------------------------------------
    // Lookup: reads pre-edge contents, never bypasses a same-cycle update.
    // -----------------------------------------------------------------------------------------
    assign w_if_idx = IF_PC[IDX_W+1:2];
    assign w_if_tag = IF_PC[31:IDX_W+2];

    assign w_if_hit   = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag) && r_ctr[w_if_idx][1];
    assign IF_hit     = w_if_hit;
    assign IF_PC_Pred = w_if_hit ? r_target[w_if_idx] : (IF_PC + 32'd4);

    // -----------------------------------------------------------------------------------------
    // Training decode
    // -----------------------------------------------------------------------------------------
    assign w_ex_idx   = EX_PC[IDX_W+1:2];
    assign w_ex_tag   = EX_PC[31:IDX_W+2];
    assign w_ex_match = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    assign w_upd      = EX_Jump || EX_Branch;
    assign w_mispred  = (EX_Jump && !EX_hit) ||
                        (EX_Branch && !EX_Jump && (EX_Taken != EX_hit));

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_target = r_target[w_ex_idx];
        w_wr_ctr    = r_ctr[w_ex_idx];
        if (EX_Jump) begin
            w_wr_en     = 1'b1;
            w_wr_target = EX_Target;
            w_wr_ctr    = 2'b11;
        end else if (EX_Branch) begin
            if (EX_Taken) begin
                w_wr_en     = 1'b1;
                w_wr_target = EX_Target;
                if (w_ex_match) begin
                    w_wr_ctr = (r_ctr[w_ex_idx] == 2'b11) ? 2'b11 : (r_ctr[w_ex_idx] + 2'd1);
                end else begin
                    // Fresh allocation starts weakly taken.
                    w_wr_ctr = 2'b10;
                end
            end else if (w_ex_match) begin
                w_wr_en  = 1'b1;
                w_wr_ctr = (r_ctr[w_ex_idx] == 2'b00) ? 2'b00 : (r_ctr[w_ex_idx] - 2'd1);
            end
            // Not-taken miss: no allocation.
        end
    end

    // -----------------------------------------------------------------------------------------
    // Table state. Every write sets valid and the tag; for a matching entry the tag is unchanged.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b00;
            end
        end else if (w_wr_en) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= w_wr_target;
            r_ctr[w_ex_idx]    <= w_wr_ctr;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Statistics: both counters stick at all-ones.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_upd && (r_br_count != CNT_MAX)) begin
                r_br_count <= r_br_count + CNT_ONE;
            end
            if (w_mispred && (r_mispred_count != CNT_MAX)) begin
                r_mispred_count <= r_mispred_count + CNT_ONE;
            end
        end
    end

    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------------------------
// tb_branch_predictor
//   Directed scenarios with literal expectations, followed by randomized training and fetch
//   traffic compared every cycle against a behavioural table model. Statistics counters are
//   narrowed so saturation is reached during the random phase.
// ---------------------------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [31:0]      IF_PC = 32'h0;
    logic             IF_hit;
    logic [31:0]      IF_PC_Pred;
    logic             EX_Branch = 1'b0;
    logic             EX_Jump = 1'b0;
    logic [31:0]      EX_PC = 32'h0;
    logic             EX_Taken = 1'b0;
    logic [31:0]      EX_Target = 32'h0;
    logic             EX_hit = 1'b0;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    always #5 clk = ~clk;

    branch_predictor #(
        .IDX_W(IDX_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IF_PC        (IF_PC),
        .IF_hit       (IF_hit),
        .IF_PC_Pred   (IF_PC_Pred),
        .EX_Branch    (EX_Branch),
        .EX_Jump      (EX_Jump),
        .EX_PC        (EX_PC),
        .EX_Taken     (EX_Taken),
        .EX_Target    (EX_Target),
        .EX_hit       (EX_hit),
        .br_count     (br_count),
        .mispred_count(mispred_count)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: one record per table slot, counter kept as an integer 0..3.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_br;
    int unsigned m_mp;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 32'h0;
            m_ctr[i]    = 0;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic model_step();
        int unsigned i;
        int unsigned t;
        bit          m;
        bit          mp;
        if (!(EX_Jump || EX_Branch)) return;
        i  = idx_of(EX_PC);
        t  = tag_of(EX_PC);
        m  = m_valid[i] && (m_tag[i] == t);
        mp = 1'b0;
        if (EX_Jump) begin
            m_valid[i] = 1'b1; m_tag[i] = t; m_target[i] = EX_Target; m_ctr[i] = 3;
            mp = !EX_hit;
        end else begin
            if (EX_Taken && m) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = EX_Target;
            end else if (EX_Taken) begin
                m_valid[i] = 1'b1; m_tag[i] = t; m_target[i] = EX_Target; m_ctr[i] = 2;
            end else if (m) begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
            mp = (EX_Taken != EX_hit);
        end
        if (m_br < CNT_MAX) m_br++;
        if (mp && m_mp < CNT_MAX) m_mp++;
    endtask

    task automatic check_outputs();
        int unsigned i;
        bit          e_hit;
        logic [31:0] e_pred;
        i      = idx_of(IF_PC);
        e_hit  = m_valid[i] && (m_tag[i] == tag_of(IF_PC)) && (m_ctr[i] >= 2);
        e_pred = e_hit ? m_target[i] : IF_PC + 32'd4;
        chk("IF_hit", 64'(IF_hit), 64'(e_hit));
        chk("IF_PC_Pred", 64'(IF_PC_Pred), 64'(e_pred));
        chk("br_count", 64'(br_count), 64'(m_br));
        chk("mispred_count", 64'(mispred_count), 64'(m_mp));
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_clear();
        else model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_ex();
        EX_Branch = 1'b0;
        EX_Jump   = 1'b0;
    endtask

    task automatic do_branch(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                             input bit hit);
        EX_Branch = 1'b1; EX_Jump = 1'b0; EX_PC = pc; EX_Taken = taken;
        EX_Target = tgt; EX_hit = hit;
        cycle();
        idle_ex();
    endtask

    task automatic lit(input string name, input logic [31:0] pc, input bit e_hit,
                       input logic [31:0] e_pred);
        IF_PC = pc;
        #1;
        chk({name, ".hit"}, 64'(IF_hit), 64'(e_hit));
        chk({name, ".pred"}, 64'(IF_PC_Pred), 64'(e_pred));
    endtask

    task automatic lit_cnt(input string name, input int unsigned e_br, input int unsigned e_mp);
        chk({name, ".br"}, 64'(br_count), 64'(e_br));
        chk({name, ".mp"}, 64'(mispred_count), 64'(e_mp));
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << (IDX_W + 2)) |
               (32'($urandom_range(0, ENTRIES - 1)) << 2) | 32'h1000;
    endfunction

    initial begin
        model_clear();
        IF_PC = 32'h100;
        #1 rst_n = 1'b0;
        @(negedge clk);
        // Reset state
        check_outputs();
        lit("t1", 32'h100, 1'b0, 32'h104);
        lit_cnt("t1", 0, 0);
        rst_n = 1'b1;
        cycle();

        // Taken branch allocates a weakly-taken entry.
        do_branch(32'h100, 1'b1, 32'h200, 1'b0);
        lit("t2", 32'h100, 1'b1, 32'h200);
        lit_cnt("t2", 1, 1);

        // Two not-taken: 10 -> 01 -> 00.
        do_branch(32'h100, 1'b0, 32'h0, 1'b1);
        lit("t3a", 32'h100, 1'b0, 32'h104);
        lit_cnt("t3a", 2, 2);
        do_branch(32'h100, 1'b0, 32'h0, 1'b0);
        lit("t3b", 32'h100, 1'b0, 32'h104);
        lit_cnt("t3b", 3, 2);

        // Four taken: 00 -> 01 -> 10 -> 11 -> 11; last one refreshes the target.
        do_branch(32'h100, 1'b1, 32'h200, 1'b1);
        do_branch(32'h100, 1'b1, 32'h200, 1'b1);
        do_branch(32'h100, 1'b1, 32'h200, 1'b1);
        do_branch(32'h100, 1'b1, 32'h300, 1'b1);
        lit("t4a", 32'h100, 1'b1, 32'h300);
        lit_cnt("t4a", 7, 2);
        do_branch(32'h100, 1'b0, 32'h0, 1'b1);
        lit("t4b", 32'h100, 1'b1, 32'h300);
        lit_cnt("t4b", 8, 3);
        do_branch(32'h100, 1'b0, 32'h0, 1'b1);
        lit("t4c", 32'h100, 1'b0, 32'h104);
        lit_cnt("t4c", 9, 4);

        // Alias on index 0: 0x140 replaces 0x100.
        do_branch(32'h140, 1'b1, 32'h400, 1'b0);
        lit("t5a", 32'h100, 1'b0, 32'h104);
        lit("t5b", 32'h140, 1'b1, 32'h400);
        lit_cnt("t5b", 10, 5);

        // Jump and branch together act as a single jump; lookup before the edge sees old entry.
        EX_Jump = 1'b1; EX_Branch = 1'b1; EX_PC = 32'h100; EX_Taken = 1'b0;
        EX_Target = 32'h500; EX_hit = 1'b1;
        lit("t5c", 32'h140, 1'b1, 32'h400);
        cycle();
        idle_ex();
        lit("t5d", 32'h100, 1'b1, 32'h500);
        lit("t5e", 32'h140, 1'b0, 32'h144);
        lit_cnt("t5e", 11, 5);
        do_branch(32'h100, 1'b0, 32'h0, 1'b1);
        lit("t5f", 32'h100, 1'b1, 32'h500);
        lit_cnt("t5f", 12, 6);

        // Asynchronous reset mid-cycle; an update pending while in reset is dropped.
        #2 rst_n = 1'b0;
        #1 model_clear();
        lit("t6a", 32'h100, 1'b0, 32'h104);
        lit_cnt("t6a", 0, 0);
        EX_Branch = 1'b1; EX_PC = 32'h100; EX_Taken = 1'b1; EX_Target = 32'h600; EX_hit = 1'b0;
        cycle();
        idle_ex();
        rst_n = 1'b1;
        cycle();
        lit("t6b", 32'h100, 1'b0, 32'h104);
        lit_cnt("t6b", 0, 0);

        // Randomized traffic; first segment is long enough to saturate both counters.
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < (seg == 0 ? 1500 : 300); c++) begin
                int sel;
                sel       = int'($urandom_range(0, 9));
                EX_Jump   = (sel <= 2);
                EX_Branch = (sel >= 2 && sel <= 6);
                EX_PC     = rand_pc();
                EX_Taken  = 1'($urandom_range(0, 1));
                EX_hit    = 1'($urandom_range(0, 1));
                EX_Target = $urandom & 32'hFFFF_FFFC;
                IF_PC     = rand_pc();
                cycle();
            end
            if (seg == 0) lit_cnt("sat", CNT_MAX, CNT_MAX);
            idle_ex();
            rst_n = 1'b0;
            cycle();
            rst_n = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
